// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;
  localparam int   OVERSAMPLE = 8;
  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/transmitter.sv
// 8N1 UART transmitter with a one-deep holding register (THR) in front of the
// shift register (TSR) so back-to-back frames leave no idle gap.
module transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic                 bclkx8,
  input  logic                 rst,
  input  logic                 tx_load,
  input  logic [DATA_BITS-1:0] THR,
  output logic                 tx_data,
  output logic                 tx_status,
  output logic                 tx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  tx_state_t            r_state, w_state_nxt;
  logic [TW-1:0]        r_tick, w_tick_nxt;
  logic [BW-1:0]        r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_thr, w_thr_nxt;
  logic [DATA_BITS-1:0] r_tsr, w_tsr_nxt;
  logic                 r_thr_full, w_thr_full_nxt;
  logic                 r_tx_data, w_tx_data_nxt;
  logic                 w_bit_end, w_load_ok;

  assign w_bit_end = (r_tick == TICK_LAST);
  // A load only lands in an empty THR; a transfer on the same edge does not free it early.
  assign w_load_ok = tx_load && !r_thr_full;

  always_ff @(posedge bclkx8 or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_bit_idx  <= '0;
      r_thr      <= '0;
      r_tsr      <= '0;
      r_thr_full <= 1'b0;
      r_tx_data  <= LINE_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_thr      <= w_thr_nxt;
      r_tsr      <= w_tsr_nxt;
      r_thr_full <= w_thr_full_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = (r_state == IDLE || w_bit_end) ? '0 : r_tick + TW'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_tsr_nxt      = r_tsr;
    w_thr_nxt      = w_load_ok ? THR : r_thr;
    w_thr_full_nxt = r_thr_full | w_load_ok;
    case (r_state)
      IDLE: if (r_thr_full) begin
        w_tsr_nxt      = r_thr;
        w_thr_full_nxt = 1'b0;
        w_state_nxt    = START;
      end
      START: if (w_bit_end) begin
        w_bit_idx_nxt = '0;
        w_state_nxt   = DATA;
      end
      DATA: if (w_bit_end) begin
        w_tsr_nxt = r_tsr >> 1;
        if (r_bit_idx == BIT_LAST) w_state_nxt = STOP;
        else                       w_bit_idx_nxt = r_bit_idx + BW'(1);
      end
      STOP: if (w_bit_end) begin
        if (r_thr_full) begin
          w_tsr_nxt      = r_thr;
          w_thr_full_nxt = 1'b0;
          w_state_nxt    = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level follows the next state so the pin is a plain flop.
    case (w_state_nxt)
      START:   w_tx_data_nxt = 1'b0;
      DATA:    w_tx_data_nxt = w_tsr_nxt[0];
      default: w_tx_data_nxt = LINE_IDLE;
    endcase
  end

  assign tx_data   = r_tx_data;
  assign tx_status = !r_thr_full;
  assign tx_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench: the line is logged per cycle and decoded by a
// behavioural 8N1 frame reader, then compared with the bytes that were sent.
module tb_transmitter;
  logic       bclkx8 = 1'b0;
  logic       rst;
  logic       tx_load;
  logic [7:0] THR;
  logic       tx_data, tx_status, tx_busy;

  int checks = 0;
  int errors = 0;

  logic       line_q[$];
  logic       busy_q[$];
  logic       stat_q[$];
  logic [7:0] dec_bytes[$];
  int         dec_starts[$];
  bit         dec_ok[$];

  transmitter dut (
    .bclkx8    (bclkx8),
    .rst       (rst),
    .tx_load   (tx_load),
    .THR       (THR),
    .tx_data   (tx_data),
    .tx_status (tx_status),
    .tx_busy   (tx_busy)
  );

  always #5 bclkx8 = ~bclkx8;

  task automatic cyc();
    @(posedge bclkx8);
    #1;
    line_q.push_back(tx_data);
    busy_q.push_back(tx_busy);
    stat_q.push_back(tx_status);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_log();
    line_q.delete(); busy_q.delete(); stat_q.delete();
  endtask

  task automatic load(input logic [7:0] b);
    tx_load = 1'b1;
    THR     = b;
    cyc();
    tx_load = 1'b0;
    THR     = 8'($urandom);
  endtask

  function automatic int busy_count();
    int n = 0;
    foreach (busy_q[i]) if (busy_q[i] === 1'b1) n++;
    return n;
  endfunction

  // Frame reader: start bit 8 low samples, 8 data bits of 8 equal samples
  // each (LSB first), stop bit 8 high samples.
  task automatic decode();
    int i;
    dec_bytes.delete(); dec_starts.delete(); dec_ok.delete();
    i = 1;
    while (i < line_q.size()) begin
      if (line_q[i] === 1'b0 && line_q[i-1] === 1'b1 && i + 80 <= line_q.size()) begin
        logic [7:0] b;
        bit ok;
        ok = 1'b1;
        b  = '0;
        for (int k = 0; k < 8; k++) if (line_q[i+k] !== 1'b0) ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
          b[n] = line_q[i+12+8*n];
          for (int k = 0; k < 8; k++) if (line_q[i+8+8*n+k] !== b[n]) ok = 1'b0;
        end
        for (int k = 0; k < 8; k++) if (line_q[i+72+k] !== 1'b1) ok = 1'b0;
        dec_bytes.push_back(b);
        dec_starts.push_back(i);
        dec_ok.push_back(ok);
        i += 80;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    #12 rst = 1'b1;
    #1;
    checks++;
    if ({tx_data, tx_status, tx_busy} !== 3'b110)
      $display("FAIL reset_async: got %b expected 110", {tx_data, tx_status, tx_busy});
    #20 rst = 1'b0;
    clear_log();
    for (int c = 0; c < 20; c++) begin
      cyc();
      checks++;
      if ({tx_data, tx_status, tx_busy} !== 3'b110) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected 110", c, {tx_data, tx_status, tx_busy});
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    clear_log();
    run(3);
    load(8'hA6);
    checks++;
    if ({tx_data, tx_status, tx_busy} !== 3'b100) begin
      errors++;
      $display("FAIL load_edge: got %b expected 100", {tx_data, tx_status, tx_busy});
    end
    cyc();
    checks++;
    if ({tx_data, tx_status, tx_busy} !== 3'b011) begin
      errors++;
      $display("FAIL start_entry: got %b expected 011", {tx_data, tx_status, tx_busy});
    end
    run(90);
    decode();
    checks++;
    if (dec_bytes.size() != 1 || dec_starts[0] != 4 || dec_bytes[0] !== 8'hA6 || !dec_ok[0]) begin
      errors++;
      $display("FAIL single_A6: got %0d frames first %h at %0d expected 1 frame a6 at 4",
               dec_bytes.size(), dec_bytes.size() ? dec_bytes[0] : 8'h00,
               dec_starts.size() ? dec_starts[0] : -1);
    end
    checks++;
    if (busy_count() != 80) begin
      errors++;
      $display("FAIL single_busy: got %0d busy cycles expected 80", busy_count());
    end
    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom);
      clear_log();
      run(2);
      load(b);
      run(85);
      decode();
      checks++;
      if (dec_bytes.size() != 1 || dec_bytes[0] !== b || !dec_ok[0]) begin
        errors++;
        $display("FAIL single_rand: got %0d frames first %h expected 1 frame %h",
                 dec_bytes.size(), dec_bytes.size() ? dec_bytes[0] : 8'h00, b);
      end
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b, input int off);
    clear_log();
    run(2);
    load(a);
    run(off);
    load(b);
    checks++;
    if (tx_status !== 1'b0) begin
      errors++;
      $display("FAIL b2b_status_full: got %b expected 0", tx_status);
    end
    run(200 - off);
    decode();
    checks++;
    if (dec_bytes.size() != 2) begin
      errors++;
      $display("FAIL b2b_frames: got %0d expected 2 (off %0d)", dec_bytes.size(), off);
    end else begin
      checks++;
      if (dec_bytes[0] !== a || dec_bytes[1] !== b || !dec_ok[0] || !dec_ok[1]) begin
        errors++;
        $display("FAIL b2b_bytes: got %h %h expected %h %h", dec_bytes[0], dec_bytes[1], a, b);
      end
      checks++;
      if (dec_starts[1] - dec_starts[0] != 80) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d expected 80", dec_starts[1] - dec_starts[0]);
      end
      checks++;
      if (stat_q[dec_starts[1]-1] !== 1'b0 || stat_q[dec_starts[1]] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_status_rise: got %b%b expected 01",
                 stat_q[dec_starts[1]-1], stat_q[dec_starts[1]]);
      end
    end
    checks++;
    if (busy_count() != 160) begin
      errors++;
      $display("FAIL b2b_busy: got %0d expected 160", busy_count());
    end
  endtask

  task automatic test_overrun();
    clear_log();
    run(2);
    load(8'hA6);
    load(8'h5A);  // lands on the transfer edge while THR is still full
    checks++;
    if (tx_status !== 1'b1) begin
      errors++;
      $display("FAIL overrun_same_edge_status: got %b expected 1", tx_status);
    end
    run(1);
    load(8'h3C);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tx_status !== 1'b0) begin
        errors++;
        $display("FAIL overrun_status: got %b expected 0", tx_status);
      end
      load(8'hFF);
      run(3);
    end
    run(230);
    decode();
    checks++;
    if (dec_bytes.size() != 2 || dec_bytes[0] !== 8'hA6 || dec_bytes[1] !== 8'h3C) begin
      errors++;
      $display("FAIL overrun_bytes: got %0d frames %h %h expected a6 3c", dec_bytes.size(),
               dec_bytes.size() > 0 ? dec_bytes[0] : 8'h00,
               dec_bytes.size() > 1 ? dec_bytes[1] : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_log();
    run(2);
    load(8'h55);  // start bit at index 3
    run(2);
    load(8'h77);  // held in THR, must be discarded by reset
    run(32);      // last sample index 37 sits in data bit 3
    checks++;
    if (line_q[31] !== 1'b1 || line_q[37] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_bits: got %b%b expected 10", line_q[31], line_q[37]);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({tx_data, tx_status, tx_busy} !== 3'b110) begin
      errors++;
      $display("FAIL mid_reset_async: got %b expected 110", {tx_data, tx_status, tx_busy});
    end
    #10 rst = 1'b0;
    clear_log();
    run(120);
    n = 0;
    foreach (line_q[i]) if (line_q[i] !== 1'b1 || busy_q[i] !== 1'b0) n++;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL mid_no_frame: got %0d non-idle cycles expected 0", n);
    end
    clear_log();
    run(2);
    load(8'h01);
    run(85);
    decode();
    checks++;
    if (dec_bytes.size() != 1 || dec_bytes[0] !== 8'h01 || !dec_ok[0]) begin
      errors++;
      $display("FAIL mid_after_reset: got %0d frames first %h expected 1 frame 01",
               dec_bytes.size(), dec_bytes.size() ? dec_bytes[0] : 8'h00);
    end
  endtask

  initial begin
    rst     = 1'b0;
    tx_load = 1'b0;
    THR     = '0;
    test_reset();
    test_single();
    test_back_to_back(8'hA6, 8'h3C, 30);
    test_back_to_back(8'($urandom), 8'($urandom), int'($urandom_range(1, 78)));
    test_back_to_back(8'($urandom), 8'($urandom), 1);
    test_back_to_back(8'($urandom), 8'($urandom), 79);
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
